// File: rtl/anabellek_hakemi.sv
// Round-robin arbiter merging N_PORT iomem masters onto one iomem port, one transaction in flight.
// Define ANABELLEK_TIMEOUT_EN to add a bus-timeout watchdog that aborts stalled transactions.
module anabellek_hakemi #(
    parameter int unsigned N_PORT      = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255,
    localparam int unsigned SW         = DATA_W / 8,
    localparam int unsigned GW         = (N_PORT > 1) ? $clog2(N_PORT) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_PORT-1:0]    m_valid_i,
    input  logic [N_PORT*SW-1:0] m_wstrb_i,
    input  logic [N_PORT*ADDR_W-1:0] m_addr_i,
    input  logic [N_PORT*DATA_W-1:0] m_wdata_i,
    output logic [N_PORT-1:0]    m_ready_o,
    output logic [DATA_W-1:0]    m_rdata_o,
    output logic                 iomem_valid_o,
    input  logic                 iomem_ready_i,
    output logic [SW-1:0]        iomem_wstrb_o,
    output logic [ADDR_W-1:0]    iomem_addr_o,
    output logic [DATA_W-1:0]    iomem_wdata_o,
    input  logic [DATA_W-1:0]    iomem_rdata_i,
    output logic [GW-1:0]        grant_o,
    output logic                 timeout_o
);

    if (N_PORT < 1 || TIMEOUT_CYC < 1 || (DATA_W % 8) != 0) begin : g_param_check
        $error("anabellek_hakemi: invalid parameter set");
    end

    typedef enum logic [1:0] {StBos, StMesgul, StYanit} state_e;

    state_e              state_q, state_d;
    logic [GW-1:0]       son_q, son_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic                valid_q, valid_d;
    logic [SW-1:0]       wstrb_q, wstrb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [N_PORT-1:0]   ready_q, ready_d;
    logic                found;
    int unsigned         win_idx;
    int unsigned         idx;

`ifdef ANABELLEK_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        son_d   = son_q;
        grant_d = grant_q;
        valid_d = valid_q;
        wstrb_d = wstrb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = '0;
`ifdef ANABELLEK_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif

        // Search starts one past the last winner, so the last winner has lowest priority.
        found   = 1'b0;
        win_idx = 0;
        idx     = 0;
        for (int unsigned i = 1; i <= N_PORT; i++) begin
            idx = (int'(son_q) + i) % N_PORT;
            if (!found && m_valid_i[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end

        unique case (state_q)
            StBos: begin
                if (found) begin
                    addr_d  = m_addr_i[win_idx*ADDR_W +: ADDR_W];
                    wdata_d = m_wdata_i[win_idx*DATA_W +: DATA_W];
                    wstrb_d = m_wstrb_i[win_idx*SW +: SW];
                    son_d   = GW'(win_idx);
                    grant_d = GW'(win_idx);
                    valid_d = 1'b1;
                    state_d = StMesgul;
`ifdef ANABELLEK_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StMesgul: begin
                if (iomem_ready_i) begin
                    rdata_d        = iomem_rdata_i;
                    valid_d        = 1'b0;
                    ready_d[son_q] = 1'b1;
                    state_d        = StYanit;
`ifdef ANABELLEK_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    rdata_d        = '1;
                    valid_d        = 1'b0;
                    ready_d[son_q] = 1'b1;
                    timeout_d      = 1'b1;
                    state_d        = StYanit;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StYanit: state_d = StBos;
            default: state_d = StBos;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StBos;
            son_q     <= GW'(N_PORT - 1);
            grant_q   <= '0;
            valid_q   <= 1'b0;
            wstrb_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ready_q   <= '0;
`ifdef ANABELLEK_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            son_q     <= son_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            wstrb_q   <= wstrb_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
`ifdef ANABELLEK_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign m_ready_o     = ready_q;
    assign m_rdata_o     = rdata_q;
    assign iomem_valid_o = valid_q;
    assign iomem_wstrb_o = wstrb_q;
    assign iomem_addr_o  = addr_q;
    assign iomem_wdata_o = wdata_q;
    assign grant_o       = grant_q;
`ifdef ANABELLEK_TIMEOUT_EN
    assign timeout_o     = timeout_q;
`else
    assign timeout_o     = 1'b0;
`endif

endmodule

// File: tb/tb_anabellek_hakemi.sv
// Directed bench for anabellek_hakemi (3 ports): scoreboard of expected m_ready_o/m_rdata_o.
module tb_anabellek_hakemi;
    localparam int unsigned NP = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned GW = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b1;
    logic [NP-1:0]     m_valid_i = '0;
    logic [NP*SW-1:0]  m_wstrb_i = '0;
    logic [NP*AW-1:0]  m_addr_i = '0;
    logic [NP*DW-1:0]  m_wdata_i = '0;
    logic [NP-1:0]     m_ready_o;
    logic [DW-1:0]     m_rdata_o;
    logic              iomem_valid_o;
    logic              iomem_ready_i = 1'b0;
    logic [SW-1:0]     iomem_wstrb_o;
    logic [AW-1:0]     iomem_addr_o;
    logic [DW-1:0]     iomem_wdata_o;
    logic [DW-1:0]     iomem_rdata_i = '0;
    logic [GW-1:0]     grant_o;
    logic              timeout_o;

    anabellek_hakemi #(
        .N_PORT     (NP),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TIMEOUT_CYC(4)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .m_valid_i    (m_valid_i),
        .m_wstrb_i    (m_wstrb_i),
        .m_addr_i     (m_addr_i),
        .m_wdata_i    (m_wdata_i),
        .m_ready_o    (m_ready_o),
        .m_rdata_o    (m_rdata_o),
        .iomem_valid_o(iomem_valid_o),
        .iomem_ready_i(iomem_ready_i),
        .iomem_wstrb_o(iomem_wstrb_o),
        .iomem_addr_o (iomem_addr_o),
        .iomem_wdata_o(iomem_wdata_o),
        .iomem_rdata_i(iomem_rdata_i),
        .grant_o      (grant_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [NP-1:0] ready;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t scb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        if (scb.size() == 0) begin
            chk({tag, "_scb_nonempty"}, 64'd0, 64'd1);
        end else begin
            e = scb.pop_front();
            chk({tag, "_ready"}, 64'(m_ready_o), 64'(e.ready));
            chk({tag, "_rdata"}, 64'(m_rdata_o), 64'(e.rdata));
        end
    endtask

    task automatic wait_iomem(input string tag);
        for (int i = 0; i < 16 && !iomem_valid_o; i++) tick();
        chk({tag, "_iomem_valid"}, 64'(iomem_valid_o), 64'd1);
    endtask

    task automatic do_txn(input string tag, input int port, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb,
                          input int waits, input logic [DW-1:0] rdata, input bit drop_early);
        m_valid_i[port]            = 1'b1;
        m_addr_i[port*AW +: AW]    = addr;
        m_wdata_i[port*DW +: DW]   = wdata;
        m_wstrb_i[port*SW +: SW]   = wstrb;
        scb.push_back('{ready: NP'(1) << port, rdata: rdata});
        tick();
        wait_iomem(tag);
        chk({tag, "_grant"}, 64'(grant_o), 64'(port));
        if (drop_early) m_valid_i[port] = 1'b0;
        for (int w = 0; w <= waits; w++) begin
            chk({tag, "_addr"}, 64'(iomem_addr_o), 64'(addr));
            chk({tag, "_wdata"}, 64'(iomem_wdata_o), 64'(wdata));
            chk({tag, "_wstrb"}, 64'(iomem_wstrb_o), 64'(wstrb));
            chk({tag, "_noready"}, 64'(m_ready_o), 64'd0);
            if (w < waits) tick();
        end
        iomem_ready_i = 1'b1;
        iomem_rdata_i = rdata;
        tick();
        iomem_ready_i = 1'b0;
        iomem_rdata_i = $urandom();
        pop_chk(tag);
        chk({tag, "_valid_low"}, 64'(iomem_valid_o), 64'd0);
        m_valid_i[port] = 1'b0;
        tick();
        chk({tag, "_pulse_end"}, 64'(m_ready_o), 64'd0);
        chk({tag, "_rdata_hold"}, 64'(m_rdata_o), 64'(rdata));
    endtask

    initial begin
        int got;
        int nrd;
        int last;

        // Reset state
        #1 rst_ni = 1'b0;
        #1;
        chk("rst_valid", 64'(iomem_valid_o), 64'd0);
        chk("rst_ready", 64'(m_ready_o), 64'd0);
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_rdata", 64'(m_rdata_o), 64'd0);
        chk("rst_timeout", 64'(timeout_o), 64'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        do_txn("read_p0", 0, 32'h0000_1000, 32'h0, 4'h0, 1, 32'hCAFE_F00D, 1'b0);
        do_txn("write_p1", 1, 32'h0000_2004, 32'h1234_5678, 4'h3, 2, 32'h0BAD_BEEF, 1'b0);

        // Downstream ready while idle must be ignored
        iomem_ready_i = 1'b1;
        iomem_rdata_i = 32'hDEAD_0000;
        tick();
        iomem_ready_i = 1'b0;
        chk("idle_ready_pulse", 64'(m_ready_o), 64'd0);
        chk("idle_rdata", 64'(m_rdata_o), 64'h0BAD_BEEF);
        chk("idle_valid", 64'(iomem_valid_o), 64'd0);
        tick();
        chk("idle_ready_pulse2", 64'(m_ready_o), 64'd0);

        do_txn("drop_p0", 0, 32'h0000_4000, 32'h0, 4'h0, 2, 32'h5555_AAAA, 1'b1);

        // Async reset mid-transaction
        m_valid_i[2]          = 1'b1;
        m_addr_i[2*AW +: AW]  = 32'h0000_3000;
        tick();
        chk("arst_pre_valid", 64'(iomem_valid_o), 64'd1);
        chk("arst_pre_grant", 64'(grant_o), 64'd2);
        m_valid_i = '0;
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_valid", 64'(iomem_valid_o), 64'd0);
        chk("arst_ready", 64'(m_ready_o), 64'd0);
        chk("arst_grant", 64'(grant_o), 64'd0);
        chk("arst_addr", 64'(iomem_addr_o), 64'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // Contention: all ports, zero-wait downstream, priority restarts at port 0
        for (int k = 0; k < int'(NP); k++) m_addr_i[k*AW +: AW] = AW'(32'h100 * k);
        for (int i = 0; i < 6; i++) scb.push_back('{ready: NP'(1) << (i % 3), rdata: 32'hA000_0000 + i});
        m_valid_i = '1;
        got  = 0;
        nrd  = 0;
        last = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            tick();
            if (m_ready_o != '0) begin
                pop_chk("rr");
                if (got > 0) chk("rr_spacing", 64'(cyc - last), 64'd3);
                last = cyc;
                got++;
                if (got == 6) m_valid_i = '0;
            end
            if (iomem_valid_o && !iomem_ready_i) begin
                chk("rr_grant", 64'(grant_o), 64'(nrd % 3));
                chk("rr_addr", 64'(iomem_addr_o), 64'(32'h100 * (nrd % 3)));
                iomem_ready_i = 1'b1;
                iomem_rdata_i = 32'hA000_0000 + nrd;
                nrd++;
            end else begin
                iomem_ready_i = 1'b0;
            end
        end
        chk("rr_count", 64'(got), 64'd6);
        iomem_ready_i = 1'b0;
        tick();
        chk("rr_idle", 64'(iomem_valid_o), 64'd0);

`ifdef ANABELLEK_TIMEOUT_EN
        m_valid_i[1]         = 1'b1;
        m_addr_i[1*AW +: AW] = 32'h0000_7000;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to_valid", 64'(iomem_valid_o), 64'd1);
            chk("to_quiet", 64'(timeout_o), 64'd0);
            if (i < 3) tick();
        end
        tick();
        chk("to_pulse", 64'(timeout_o), 64'd1);
        chk("to_ready", 64'(m_ready_o), 64'h2);
        chk("to_rdata", 64'(m_rdata_o), 64'hFFFF_FFFF);
        chk("to_valid_low", 64'(iomem_valid_o), 64'd0);
        m_valid_i = '0;
        tick();
        chk("to_pulse_end", 64'(timeout_o), 64'd0);
        chk("to_ready_end", 64'(m_ready_o), 64'd0);
`else
        chk("no_timeout", 64'(timeout_o), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/anabellek_hakemi.md
# anabellek_hakemi

Parametrised main-memory arbiter that merges `N_PORT` iomem-style masters onto one iomem port toward the SoC memory bus. It generalises the fixed two-master (instruction cache + data cache) memory controller to any port count. It uses registered round-robin arbitration and a single outstanding transaction. An optional bus-timeout watchdog is compiled in by macro. It sits between the L1 caches (plus future DMA/peripheral masters) and the top-level `iomem_*` pins.

## Interface
- `N_PORT`, 2, number of master ports (≥1)
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (multiple of 8); strobe width `DATA_W/8`
- `TIMEOUT_CYC`, 255, watchdog limit in cycles (used only with the macro; ≥1)

Ports:
- `clk_i`  in  1  single clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `m_valid_i`  in  N_PORT  per-master request valid; held until that master's `m_ready_o`
- `m_wstrb_i`  in  N_PORT*DATA_W/8  per-master byte strobes; all-zero = read
- `m_addr_i`  in  N_PORT*ADDR_W  per-master address, port k at slice k
- `m_wdata_i`  in  N_PORT*DATA_W  per-master write data
- `m_ready_o`  out  N_PORT  one-cycle completion pulse, one-hot
- `m_rdata_o`  out  DATA_W  read data shared by all masters; valid when `m_ready_o[k]`
- `iomem_valid_o`  out  1  downstream request valid
- `iomem_ready_i`  in  1  downstream completion
- `iomem_wstrb_o`  out  DATA_W/8  downstream strobes
- `iomem_addr_o`  out  ADDR_W  downstream address
- `iomem_wdata_o`  out  DATA_W  downstream write data
- `iomem_rdata_i`  in  DATA_W  downstream read data
- `grant_o`  out  max(1,$clog2(N_PORT))  index of the current or last granted master
- `timeout_o`  out  1  one-cycle pulse on watchdog abort

## Operation
- FSM states: BOS (idle), MESGUL (downstream busy), YANIT (response).
- **BOS**
  - If any `m_valid_i` is set, select a winner by round-robin, searching from `(son+1) mod N_PORT` upward with wrap.
  - Latch the winner's addr/wdata/wstrb into the output registers. Set `son` and `grant_o` to the winner. Set `iomem_valid_o` to 1. Go to MESGUL.
  - If no request, stay in BOS.
- **MESGUL**
  - Output registers are held stable.
  - On `iomem_ready_i`: capture `iomem_rdata_i` into `m_rdata_o`, clear `iomem_valid_o`, set `m_ready_o[son]`, go to YANIT.
- **YANIT**
  - `m_ready_o[son]` is high for exactly this cycle. Clear it and go to BOS.
  - The master drops `m_valid_i` in the cycle after it sees ready. The cycle delay through YANIT keeps a stale valid from being regranted.
- Reset values:
  - `son` = N_PORT-1, so port 0 wins the first contest.
  - All outputs 0.
  - State is BOS.
- `m_rdata_o` holds its last captured value between transactions. For writes it carries whatever `iomem_rdata_i` held at completion.
- Boundary conditions:
  - `iomem_ready_i` outside MESGUL is ignored.
  - A master that deasserts `m_valid_i` during MESGUL does not abort the transaction. It still receives `m_ready_o`.
  - Simultaneous requests from all ports are served in strict rotation, with no starvation: worst-case wait is N_PORT-1 transactions.
  - `N_PORT=1` degenerates to a registered pass-through with `grant_o`=0.
  - `rst_ni` low at any time, including mid-MESGUL, immediately clears all state and outputs. The abandoned downstream transaction is not completed.

## Timing
- Request sampled in cycle t (BOS) → `iomem_valid_o` high from t+1.
- `iomem_ready_i` sampled in cycle r → `m_ready_o` and `m_rdata_o` valid in r+1.
- BOS in r+2 → next `iomem_valid_o` no earlier than r+3.
- Minimum master-visible latency is 3 cycles, for zero-wait downstream (ready in t+1).
- Throughput is at most one transaction per 3 cycles.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- Macro `ANABELLEK_TIMEOUT_EN`.
- **Defined:** a counter clears on entry to MESGUL and increments each MESGUL cycle without ready. On reaching `TIMEOUT_CYC`:
  - `iomem_valid_o` clears.
  - `m_rdata_o` is set to all ones.
  - `m_ready_o[son]` and `timeout_o` pulse together for one cycle via YANIT.
  - If ready arrives in the same cycle as the limit, ready wins and there is no timeout.
- **Undefined:** no counter. MESGUL waits indefinitely and `timeout_o` is tied 0.

## Test plan
- Single read: port 0 requests addr 0x1000, downstream ready after 2 cycles with rdata 0xCAFEF00D → `iomem_addr_o`=0x1000, `m_ready_o`=01 for one cycle, `m_rdata_o`=0xCAFEF00D.
- Contention, N_PORT=3: all ports request continuously with zero-wait downstream → grant order 0,1,2,0,1,2; each `m_ready_o` pulse is 3 cycles apart.
- Write: port 1 writes wstrb 0x3, wdata 0x12345678 → same values on `iomem_*_o`, stable until ready; `m_ready_o`=10.
- Valid dropped mid-transaction: port 0 deasserts during MESGUL → transaction still completes and `m_ready_o[0]` pulses.
- Async reset mid-MESGUL: `rst_ni` low → `iomem_valid_o`, `m_ready_o`, `grant_o` go 0 immediately. After release, port 0 has priority again.
- With `ANABELLEK_TIMEOUT_EN`, TIMEOUT_CYC=4, ready never asserted → after 4 MESGUL cycles `timeout_o`=1, `m_rdata_o`=0xFFFFFFFF, FSM returns to BOS.
